acc_uart_sender: RTL and testbench

ACC_UART_SENDER -- requirements
Module: acc_uart_sender

---
 rtl/acc_uart_sender_pkg.sv | 29 ++
 rtl/acc_uart_sender_edge.sv | 23 ++
 rtl/acc_uart_sender.sv | 98 +++++++++
 tb/tb_acc_uart_sender.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_uart_sender_pkg.sv
// Shared types and constants for the accumulator UART sender.
// State encoding and byte-count helper.
package acc_uart_sender_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    START = S_START,
    WAIT  = S_WAIT,
    NEXT  = S_NEXT,
    DONE  = S_DONE
  } state_t;

  localparam int N_BUS_DEF   = 16;
  localparam int N_DATA_DEF  = 8;
  localparam int N_BYTES_DEF = N_BUS_DEF / N_DATA_DEF;

  function automatic int n_bytes(input int nbus, input int ndata);
    return nbus / ndata;
  endfunction

endpackage

// File: rtl/acc_uart_sender_edge.sv
// Registered rising-edge detector.
// Sample resets high so a level held through reset never fires.
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_pulse
);

  logic sample;

  // one-cycle pulse when the input goes 0 -> 1
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sample  <= 1'b1;
      o_pulse <= 1'b0;
    end else begin
      sample  <= i_sig;
      o_pulse <= i_sig & ~sample;
    end
  end

endmodule

// File: rtl/acc_uart_sender.sv
// Sends a captured accumulator value, MSB byte first,
// to an external UART transmitter on a halt rising edge.
module acc_uart_sender
  import acc_uart_sender_pkg::*;
#(
  parameter int N_BUS  = 16,
  parameter int N_DATA = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_BUS-1:0]  i_ACC,
  input  logic              i_halt,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [N_DATA-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int NB = n_bytes(N_BUS, N_DATA);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(NB - 1);

  state_t           state;
  logic [N_BUS-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_dec;
  logic             halt_rise;

  assign cnt_dec = cnt - CW'(1);

  edge_detect_rise u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_halt),
    .o_pulse (halt_rise)
  );

  // control FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      cnt        <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (halt_rise) begin
            state  <= LOAD;
            o_busy <= 1'b1;
          end
        end
        LOAD: begin
          shadow     <= i_ACC;
          cnt        <= CNT_TOP;
          o_tx_data  <= i_ACC[(NB-1)*N_DATA +: N_DATA];
          o_tx_start <= 1'b1;
          state      <= START;
        end
        START: begin
          o_tx_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) state <= NEXT;
        end
        NEXT: begin
          if (cnt == '0) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            cnt        <= cnt_dec;
            o_tx_data  <= shadow[int'(cnt_dec)*N_DATA +: N_DATA];
            o_tx_start <= 1'b1;
            state      <= START;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_tx_start <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_uart_sender.sv
// Scoreboard bench for acc_uart_sender.
// Random and directed sends, UART TX responder model.
module tb_acc_uart_sender;

  localparam int N_BUS  = 16;
  localparam int N_DATA = 8;
  localparam int NB     = N_BUS / N_DATA;

  logic              clk;
  logic              rst_n;
  logic [N_BUS-1:0]  acc;
  logic              halt;
  logic              tx_done;
  logic              tx_start;
  logic [N_DATA-1:0] tx_data;
  logic              busy;
  logic              done;

  int errors;
  int checks;
  int cyc;
  int n_start;
  int n_done;
  int halt_cyc;
  int arm_id;
  int seen_id;
  int resp_dly;
  bit glitch;
  int poke;
  int poke_seen;
  int exp_q[$];

  acc_uart_sender #(.N_BUS(N_BUS), .N_DATA(N_DATA)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ACC      (acc),
    .i_halt     (halt),
    .i_tx_done  (tx_done),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops scoreboard on each start or done pulse
  always @(negedge clk) begin
    int e;
    if (tx_start) begin
      n_start++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: data=%0h none expected", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (e != int'(tx_data)) begin
          errors++;
          $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
        end
      end
      if (seen_id != arm_id) begin
        seen_id = arm_id;
        checks++;
        if (cyc - halt_cyc != 3) begin
          errors++;
          $display("FAIL latency: got %0d expected 3", cyc - halt_cyc);
        end
      end
    end
    if (done) begin
      n_done++;
      checks++;
      if (exp_q.size() == 0 || exp_q[0] != -1) begin
        errors++;
        $display("FAIL done_pulse: unexpected done, queue size %0d", exp_q.size());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  // UART TX model: answers each start with a done pulse
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (glitch) begin
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
        end
        repeat (resp_dly) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end else if (poke != poke_seen) begin
        poke_seen = poke;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end
    end
  end

  task automatic send(input logic [N_BUS-1:0] v, input int dly);
    resp_dly = dly;
    acc = v;
    for (int k = NB - 1; k >= 0; k--)
      exp_q.push_back(int'((v >> (k * N_DATA)) & ((1 << N_DATA) - 1)));
    exp_q.push_back(-1);
    @(posedge clk); #1;
    halt = 1'b1;
    halt_cyc = cyc;
    arm_id++;
  endtask

  task automatic wait_done(input int target);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      if (n_done >= target) break;
    end
    #1;
    if (k == 400) begin
      checks++;
      errors++;
      $display("FAIL timeout: done count %0d expected %0d", n_done, target);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, int'(tx_start), 0);
    chk({tag, "_data"}, int'(tx_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int s0;
    errors = 0; checks = 0; cyc = 0;
    n_start = 0; n_done = 0; arm_id = 0; seen_id = 0;
    halt_cyc = 0; resp_dly = 10; glitch = 1'b0;
    poke = 0; poke_seen = 0;
    rst_n = 1'b0; acc = '0; halt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    send(16'h1234, 10);
    wait_done(n_done + 1);
    halt = 1'b0;
    chk("busy_after_1234", int'(busy), 0);
    chk("queue_1234", exp_q.size(), 0);

    send(16'hFFFE, 10);
    repeat (6) @(posedge clk); #1;
    acc = 16'h0000;
    wait_done(n_done + 1);
    halt = 1'b0;

    s0 = n_start;
    send(16'hA55A, 10);
    repeat (6) @(posedge clk); #1;
    halt = 1'b0;
    @(posedge clk); #1;
    halt = 1'b1;
    wait_done(n_done + 1);
    repeat (100) @(posedge clk); #1;
    chk("starts_drop_hold", n_start - s0, 2);
    halt = 1'b0;
    @(posedge clk); #1;

    s0 = n_start;
    poke++;
    repeat (5) @(posedge clk); #1;
    chk("idle_done_busy", int'(busy), 0);
    chk("idle_done_starts", n_start - s0, 0);

    glitch = 1'b1;
    send(16'h7E81, 4);
    wait_done(n_done + 1);
    halt = 1'b0;
    glitch = 1'b0;
    chk("glitch_starts", n_start - s0, 2);

    for (int i = 0; i < 8; i++) begin
      send(N_BUS'($urandom), $urandom_range(1, 12));
      wait_done(n_done + 1);
      halt = 1'b0;
    end
    chk("queue_random", exp_q.size(), 0);

    send(16'hC3D2, 10);
    repeat (6) @(posedge clk); #1;
    chk("busy_in_wait", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    exp_q.delete();
    s0 = n_start;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk); #1;
    chk("held_halt_starts", n_start - s0, 0);
    chk("held_halt_busy", int'(busy), 0);
    halt = 1'b0;
    repeat (2) @(posedge clk); #1;

    send(16'h0BAD, 3);
    wait_done(n_done + 1);
    halt = 1'b0;
    chk("starts_after_rst", n_start - s0, 2);
    chk("queue_final", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
